// File: rtl/axi4_manager_if.sv
// AXI4 bus bundle shared by the manager and its subordinate.
// The master modport is the manager side; the slave modport is the subordinate side.
interface axi4_manager_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_manager.sv
// AXI4 manager turning level requests into single-ID INCR bursts.
// Write (AW/W/B) and read (AR/R) channels run independent FSMs.
module axi4_manager #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXI_XSIZE        = 8,
  parameter int DATA_COUNT_WIDTH = 8,
  parameter int WORD_SIZE_BYTES  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_wr_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_rd_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_data_i,
  input  logic [DATA_COUNT_WIDTH-1:0] wr_data_count_i,
  input  logic [DATA_COUNT_WIDTH-1:0] rd_data_count_i,
  output logic [1:0]                  rsp_o,
  output logic [1:0]                  wr_err_o,
  output logic [1:0]                  rd_err_o,
  output logic [AXI_DATA_WIDTH-1:0]   axi_data_o,
  output logic [1:0]                  dbg_wr_state_o,
  output logic [1:0]                  dbg_rd_state_o,
  axi4_manager_if.master              axi_mgr_if
);
  localparam logic [2:0] AX_SIZE = 3'($clog2(AXI_XSIZE));
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    {AXI_ADDR_WIDTH{1'b1}} << $clog2(WORD_SIZE_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;

  wr_state_e                 r_wr_state, w_wr_next;
  rd_state_e                 r_rd_state, w_rd_next;
  logic [AXI_ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
  logic [7:0]                r_wr_len, r_rd_len, r_wr_cnt;
  logic [1:0]                r_wr_err, r_rd_err, r_rd_first_err;
  logic                      r_wr_rsp, r_rd_rsp;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      w_wr_last;
  logic                      w_unused;

  assign w_wr_last = (r_wr_cnt == r_wr_len);

  // Fixed burst attributes: ID 0, INCR, normal access, full strobes.
  assign axi_mgr_if.aw_id     = '0;
  assign axi_mgr_if.aw_addr   = r_wr_addr;
  assign axi_mgr_if.aw_len    = r_wr_len;
  assign axi_mgr_if.aw_size   = AX_SIZE;
  assign axi_mgr_if.aw_burst  = 2'b01;
  assign axi_mgr_if.aw_lock   = 1'b0;
  assign axi_mgr_if.aw_cache  = '0;
  assign axi_mgr_if.aw_prot   = '0;
  assign axi_mgr_if.aw_qos    = '0;
  assign axi_mgr_if.aw_region = '0;
  assign axi_mgr_if.aw_atop   = '0;
  assign axi_mgr_if.aw_user   = '0;
  assign axi_mgr_if.w_data    = axi_data_i;
  assign axi_mgr_if.w_strb    = '1;
  assign axi_mgr_if.w_last    = w_wr_last;
  assign axi_mgr_if.w_user    = '0;
  assign axi_mgr_if.ar_id     = '0;
  assign axi_mgr_if.ar_addr   = r_rd_addr;
  assign axi_mgr_if.ar_len    = r_rd_len;
  assign axi_mgr_if.ar_size   = AX_SIZE;
  assign axi_mgr_if.ar_burst  = 2'b01;
  assign axi_mgr_if.ar_lock   = 1'b0;
  assign axi_mgr_if.ar_cache  = '0;
  assign axi_mgr_if.ar_prot   = '0;
  assign axi_mgr_if.ar_qos    = '0;
  assign axi_mgr_if.ar_region = '0;
  assign axi_mgr_if.ar_user   = '0;

  assign rsp_o          = {r_rd_rsp, r_wr_rsp};
  assign wr_err_o       = r_wr_err;
  assign rd_err_o       = r_rd_err;
  assign axi_data_o     = r_rdata;
  assign dbg_wr_state_o = r_wr_state;
  assign dbg_rd_state_o = r_rd_state;
  assign w_unused = ^{axi_mgr_if.b_id, axi_mgr_if.b_user, axi_mgr_if.r_id, axi_mgr_if.r_user};

  // Handshakes: a VALID depends only on FSM state, so once raised it stays
  // high with stable payload until the cycle READY is seen; transfer = VALID & READY.
  always_comb begin
    w_wr_next           = r_wr_state;
    axi_mgr_if.aw_valid = 1'b0;
    axi_mgr_if.w_valid  = 1'b0;
    axi_mgr_if.b_ready  = 1'b0;
    case (r_wr_state)
      W_IDLE: if (req_i[0]) w_wr_next = W_AW;
      W_AW: begin
        axi_mgr_if.aw_valid = 1'b1;
        if (axi_mgr_if.aw_ready) w_wr_next = W_DATA;
      end
      W_DATA: begin
        axi_mgr_if.w_valid = 1'b1;
        if (axi_mgr_if.w_ready && w_wr_last) w_wr_next = W_RESP;
      end
      W_RESP: begin
        axi_mgr_if.b_ready = 1'b1;
        if (axi_mgr_if.b_valid) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_err   <= '0;
      r_wr_rsp   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_wr_rsp   <= 1'b0;
      case (r_wr_state)
        W_IDLE: if (req_i[0]) begin
          r_wr_addr <= axi_wr_addr_i & ADDR_MASK;
          r_wr_len  <= 8'(wr_data_count_i);
        end
        W_AW:   r_wr_cnt <= '0;
        W_DATA: if (axi_mgr_if.w_ready) r_wr_cnt <= r_wr_cnt + 8'd1;
        W_RESP: if (axi_mgr_if.b_valid) begin
          r_wr_err <= axi_mgr_if.b_resp;
          r_wr_rsp <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_next           = r_rd_state;
    axi_mgr_if.ar_valid = 1'b0;
    axi_mgr_if.r_ready  = 1'b0;
    case (r_rd_state)
      R_IDLE: if (req_i[1]) w_rd_next = R_AR;
      R_AR: begin
        axi_mgr_if.ar_valid = 1'b1;
        if (axi_mgr_if.ar_ready) w_rd_next = R_DATA;
      end
      R_DATA: begin
        axi_mgr_if.r_ready = 1'b1;
        if (axi_mgr_if.r_valid && axi_mgr_if.r_last) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // r_rd_first_err tracks the burst in flight; rd_err_o only moves at completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state     <= R_IDLE;
      r_rd_addr      <= '0;
      r_rd_len       <= '0;
      r_rd_first_err <= '0;
      r_rd_err       <= '0;
      r_rd_rsp       <= 1'b0;
      r_rdata        <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      r_rd_rsp   <= 1'b0;
      case (r_rd_state)
        R_IDLE: if (req_i[1]) begin
          r_rd_addr      <= axi_rd_addr_i & ADDR_MASK;
          r_rd_len       <= 8'(rd_data_count_i);
          r_rd_first_err <= '0;
        end
        R_DATA: if (axi_mgr_if.r_valid) begin
          r_rdata <= axi_mgr_if.r_data;
          if (r_rd_first_err == 2'b00) r_rd_first_err <= axi_mgr_if.r_resp;
          if (axi_mgr_if.r_last) begin
            r_rd_err <= (r_rd_first_err != 2'b00) ? r_rd_first_err : axi_mgr_if.r_resp;
            r_rd_rsp <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_manager.sv
// Bench for axi4_manager: reactive AXI subordinate model, burst scoreboard
// and directed scenarios with literal expectations.
module tb_axi4_manager;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;
  localparam int UW  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req = 2'b00;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [7:0]    wr_cnt = '0, rd_cnt = '0;
  logic [1:0]    rsp, wr_err, rd_err, dbg_w, dbg_r;
  logic [DW-1:0] data_out;

  axi4_manager_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                    .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW)) bus ();

  axi4_manager #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_XSIZE(8),
                 .DATA_COUNT_WIDTH(8), .WORD_SIZE_BYTES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .axi_wr_addr_i(wr_addr), .axi_rd_addr_i(rd_addr), .axi_data_i(data_in),
    .wr_data_count_i(wr_cnt), .rd_data_count_i(rd_cnt),
    .rsp_o(rsp), .wr_err_o(wr_err), .rd_err_o(rd_err), .axi_data_o(data_out),
    .dbg_wr_state_o(dbg_w), .dbg_rd_state_o(dbg_r),
    .axi_mgr_if(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] req_v);
    checks++;
    if (act_v !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act_v, req_v, $time);
    end
  endtask

  // ---------------- model configuration (set by stimulus) ----------------
  logic [AW-1:0] cfg_wr_addr = '0, cfg_rd_addr = '0;
  logic [7:0]    cfg_wr_cnt = '0, cfg_rd_cnt = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int            cfg_rerr_beat = -1;
  bit            cfg_rand = 1'b0;

  // ---------------- subordinate + scoreboard state ----------------
  logic [DW:0]   exp_q[$];   // {last, data} per expected W beat
  bit            w_open, b_pend, r_open, r_live;
  int            b_dly, r_len, r_beat, r_gap;
  logic [1:0]    r_first_err;
  logic [DW-1:0] cur_rdata;
  logic [1:0]    m_wr_err, m_rd_err;
  logic [DW-1:0] m_rdata;
  bit            exp_wp, exp_rp;
  bit            p_aw_pend, p_w_pend, p_ar_pend;
  logic [AW-1:0] p_aw_addr, p_ar_addr;
  logic [7:0]    p_aw_len, p_ar_len;
  logic          p_w_last;
  int aw_hs = 0, w_hs = 0, wlast_hs = 0, ar_hs = 0, r_hs = 0;
  int wr_done = 0, rd_done = 0, wr_pulses = 0, rd_pulses = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [7:0]    cap_awlen, cap_arlen;
  logic [2:0]    cap_awsize, cap_arsize;
  logic [1:0]    cap_awburst;
  logic [7:0]    cap_wstrb;

  task automatic model_clear();
    exp_q.delete();
    w_open = 0; b_pend = 0; r_open = 0; r_live = 0;
    b_dly = 0; r_len = 0; r_beat = 0; r_gap = 0; r_first_err = 0;
    m_wr_err = 0; m_rd_err = 0; m_rdata = 0; exp_wp = 0; exp_rp = 0;
    p_aw_pend = 0; p_w_pend = 0; p_ar_pend = 0;
    bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
    bus.b_valid = 0; bus.b_resp = 0; bus.b_id = 0; bus.b_user = 0;
    bus.r_valid = 0; bus.r_resp = 0; bus.r_data = 0; bus.r_last = 0;
    bus.r_id = 0; bus.r_user = 0;
  endtask

  // ---------------- compare process + reactive subordinate ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rsp_err", {rsp, wr_err, rd_err}, 64'd0);
      chk("rst_rdata", data_out, 64'd0);
      chk("rst_valid_ready", {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}, 64'd0);
      model_clear();
    end else begin
      chk("rsp", rsp, {exp_rp, exp_wp});
      if (rsp[0]) wr_pulses++;
      if (rsp[1]) rd_pulses++;
      chk("wr_err", wr_err, m_wr_err);
      chk("rd_err", rd_err, m_rd_err);
      chk("rdata_out", data_out, m_rdata);
      exp_wp = 0; exp_rp = 0;
      if (p_aw_pend) chk("aw_stable", {bus.aw_valid, bus.aw_addr, bus.aw_len}, {1'b1, p_aw_addr, p_aw_len});
      if (p_ar_pend) chk("ar_stable", {bus.ar_valid, bus.ar_addr, bus.ar_len}, {1'b1, p_ar_addr, p_ar_len});
      if (p_w_pend)  chk("w_stable", {bus.w_valid, bus.w_last}, {1'b1, p_w_last});

      bus.aw_ready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.w_ready  = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ar_ready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_pend && b_dly == 0) begin
        bus.b_valid = 1; bus.b_resp = cfg_bresp;
      end else begin
        bus.b_valid = 0; bus.b_resp = 0;
        if (b_pend) b_dly--;
      end
      if (r_open && !r_live) begin
        if (r_gap > 0) r_gap--;
        else begin r_live = 1; cur_rdata = {$urandom, $urandom}; end
      end
      bus.r_valid = r_live;
      bus.r_data  = r_live ? cur_rdata : '0;
      bus.r_resp  = (r_live && r_beat == cfg_rerr_beat) ? cfg_rresp : 2'b00;
      bus.r_last  = r_live && (r_beat == r_len);
      #1;

      if (bus.w_valid) begin
        chk("w_after_aw", 64'(w_open), 64'd1);
        if (bus.w_ready && w_open) begin
          logic [DW:0] e;
          w_hs++;
          chk("w_expected", 64'(exp_q.size() != 0), 64'd1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          chk("w_data", bus.w_data, e[DW-1:0]);
          chk("w_last", 64'(bus.w_last), 64'(e[DW]));
          chk("w_strb", bus.w_strb, 64'hFF);
          cap_wstrb = bus.w_strb;
          if (bus.w_last) wlast_hs++;
          if (e[DW]) begin
            w_open = 0; b_pend = 1;
            b_dly = cfg_rand ? int'($urandom_range(0, 3)) : 0;
          end
        end
      end
      if (bus.aw_valid && bus.aw_ready) begin
        aw_hs++;
        chk("aw_single_outstanding", {w_open, b_pend}, 64'd0);
        chk("aw_fields", {bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst},
            {cfg_wr_addr & 32'hFFFF_FFFC, cfg_wr_cnt, 3'd3, 2'b01});
        chk("aw_zero_fields", {bus.aw_id, bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos,
                               bus.aw_region, bus.aw_atop, bus.aw_user}, 64'd0);
        cap_awaddr = bus.aw_addr; cap_awlen = bus.aw_len;
        cap_awsize = bus.aw_size; cap_awburst = bus.aw_burst;
        exp_q.delete();
        for (int i = 0; i <= int'(cfg_wr_cnt); i++) exp_q.push_back({i == int'(cfg_wr_cnt), cfg_wr_data});
        w_open = 1;
      end
      if (bus.b_valid) chk("b_ready", 64'(bus.b_ready), 64'd1);
      if (bus.b_valid && bus.b_ready) begin
        b_pend = 0; exp_wp = 1; m_wr_err = cfg_bresp; wr_done++;
      end
      if (bus.r_valid) chk("r_ready", 64'(bus.r_ready), 64'd1);
      if (bus.r_valid && bus.r_ready) begin
        r_hs++; m_rdata = cur_rdata; r_live = 0;
        if (r_beat == cfg_rerr_beat && r_first_err == 2'b00) r_first_err = cfg_rresp;
        if (r_beat == r_len) begin
          exp_rp = 1; m_rd_err = r_first_err; r_open = 0; rd_done++;
        end else begin
          r_beat++;
          r_gap = cfg_rand ? int'($urandom_range(0, 3)) : 0;
        end
      end
      if (bus.ar_valid && bus.ar_ready) begin
        ar_hs++;
        chk("ar_single_outstanding", 64'(r_open), 64'd0);
        chk("ar_fields", {bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst},
            {cfg_rd_addr & 32'hFFFF_FFFC, cfg_rd_cnt, 3'd3, 2'b01});
        cap_araddr = bus.ar_addr; cap_arlen = bus.ar_len; cap_arsize = bus.ar_size;
        r_open = 1; r_len = int'(cfg_rd_cnt); r_beat = 0; r_live = 0; r_first_err = 0;
        r_gap = cfg_rand ? int'($urandom_range(0, 3)) : 0;
      end
      p_aw_pend = bus.aw_valid && !bus.aw_ready; p_aw_addr = bus.aw_addr; p_aw_len = bus.aw_len;
      p_ar_pend = bus.ar_valid && !bus.ar_ready; p_ar_addr = bus.ar_addr; p_ar_len = bus.ar_len;
      p_w_pend  = bus.w_valid && !bus.w_ready;   p_w_last  = bus.w_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_wr(input logic [AW-1:0] a, input logic [7:0] c, input logic [DW-1:0] d,
                        input logic [1:0] bresp);
    cfg_wr_addr = a; cfg_wr_cnt = c; cfg_wr_data = d; cfg_bresp = bresp;
    wr_addr = a; wr_cnt = c; data_in = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [7:0] c, input logic [1:0] rresp,
                        input int err_beat);
    cfg_rd_addr = a; cfg_rd_cnt = c; cfg_rresp = rresp; cfg_rerr_beat = err_beat;
    rd_addr = a; rd_cnt = c;
  endtask

  task automatic pulse_req(input logic [1:0] r);
    @(posedge clk); #2 req = r;
    @(posedge clk); #2 req = 2'b00;
  endtask

  task automatic wait_done(input string name, input int wt, input int rt);
    int n = 0;
    while ((wr_done < wt || rd_done < rt) && n < 3000) begin
      @(posedge clk); n++;
    end
    chk(name, 64'(n < 3000), 64'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w0, r0, wl0, wp0, rp0, n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("reset_outputs", {rsp, wr_err, rd_err, dbg_w, dbg_r}, 64'd0);

    // 8-beat write, always-ready subordinate
    cfg_rand = 0;
    set_wr(32'h5000, 8'd7, 64'hDEADBEEF0B501E7E, 2'b00);
    w0 = w_hs; wl0 = wlast_hs; wp0 = wr_pulses;
    pulse_req(2'b01);
    wait_done("t1_done", wr_done + 1, rd_done);
    chk("t1_awaddr", cap_awaddr, 64'h5000);
    chk("t1_awlen", cap_awlen, 64'd7);
    chk("t1_awsize", cap_awsize, 64'd3);
    chk("t1_awburst", cap_awburst, 64'd1);
    chk("t1_wstrb", cap_wstrb, 64'hFF);
    chk("t1_beats", 64'(w_hs - w0), 64'd8);
    chk("t1_wlasts", 64'(wlast_hs - wl0), 64'd1);
    chk("t1_pulses", 64'(wr_pulses - wp0), 64'd1);
    chk("t1_wr_err", wr_err, 64'd0);

    // 8-beat read, random-delay subordinate
    cfg_rand = 1;
    set_rd(32'h6000, 8'd7, 2'b00, -1);
    r0 = r_hs; rp0 = rd_pulses;
    pulse_req(2'b10);
    wait_done("t2_done", wr_done, rd_done + 1);
    chk("t2_araddr", cap_araddr, 64'h6000);
    chk("t2_arlen", cap_arlen, 64'd7);
    chk("t2_arsize", cap_arsize, 64'd3);
    chk("t2_beats", 64'(r_hs - r0), 64'd8);
    chk("t2_pulses", 64'(rd_pulses - rp0), 64'd1);
    chk("t2_rd_err", rd_err, 64'd0);

    // single beat, unaligned address
    cfg_rand = 0;
    set_wr(32'h5003, 8'd0, 64'h0123456789ABCDEF, 2'b00);
    w0 = w_hs; wl0 = wlast_hs;
    pulse_req(2'b01);
    wait_done("t4_done", wr_done + 1, rd_done);
    chk("t4_awaddr", cap_awaddr, 64'h5000);
    chk("t4_awlen", cap_awlen, 64'd0);
    chk("t4_beats", 64'(w_hs - w0), 64'd1);
    chk("t4_wlasts", 64'(wlast_hs - wl0), 64'd1);

    // error responses on both channels, concurrent
    cfg_rand = 1;
    set_wr(32'h8010, 8'd3, 64'hA5A5_5A5A_F00D_CAFE, 2'b10);
    set_rd(32'h9020, 8'd3, 2'b11, 2);
    pulse_req(2'b11);
    wait_done("t5_done", wr_done + 1, rd_done + 1);
    chk("t5_wr_err", wr_err, 64'd2);
    chk("t5_rd_err", rd_err, 64'd3);
    repeat (5) @(posedge clk);
    #2;
    chk("t5_wr_err_hold", wr_err, 64'd2);
    chk("t5_rd_err_hold", rd_err, 64'd3);
    set_rd(32'h9040, 8'd2, 2'b00, -1);
    pulse_req(2'b10);
    wait_done("t5b_done", wr_done, rd_done + 1);
    chk("t5b_rd_err_clear", rd_err, 64'd0);
    chk("t5b_wr_err_kept", wr_err, 64'd2);
    cfg_bresp = 2'b00;

    // held request: repeated concurrent bursts with random readiness
    set_wr(32'hA000, 8'd2, 64'h1111_2222_3333_4444, 2'b00);
    set_rd(32'hB004, 8'd4, 2'b00, -1);
    w0 = wr_done; r0 = rd_done; wp0 = wr_pulses; rp0 = rd_pulses;
    @(posedge clk); #2 req = 2'b11;
    wait_done("t3_done", w0 + 4, r0 + 4);
    req = 2'b00;
    n = 0;
    while ((dbg_w != 2'd0 || dbg_r != 2'd0) && n < 500) begin @(posedge clk); #2; n++; end
    chk("t3_idle", 64'(n < 500), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    chk("t3_wr_pulse_count", 64'(wr_pulses - wp0), 64'(wr_done - w0));
    chk("t3_rd_pulse_count", 64'(rd_pulses - rp0), 64'(rd_done - r0));

    // reset in the middle of the write data phase
    set_wr(32'hC000, 8'd7, 64'hFEED_FACE_0000_0001, 2'b00);
    pulse_req(2'b01);
    n = 0;
    while (!bus.w_valid && n < 200) begin @(posedge clk); #2; n++; end
    chk("t6_reached_wdata", 64'(bus.w_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_drop", {bus.aw_valid, bus.w_valid, rsp, dbg_w}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cfg_rand = 0;
    set_wr(32'h7000, 8'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00);
    w0 = w_hs;
    pulse_req(2'b01);
    wait_done("t6_done", wr_done + 1, rd_done);
    chk("t6_awaddr", cap_awaddr, 64'h7000);
    chk("t6_beats", 64'(w_hs - w0), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_manager.md
Name: axi4_manager

Overview:
- Generic AXI4 manager converting simple level requests into AXI4 INCR bursts on an AXI_BUS manager interface.
- Independent write and read channels, each with its own FSM, so both can run concurrently.
- Sits between local control logic and an AXI4 subordinate/interconnect; reports completion and response codes.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data bus width.
- AXI_XSIZE, 8, bytes per beat (power of 2, at most AXI_DATA_WIDTH/8); AxSIZE = log2(AXI_XSIZE).
- DATA_COUNT_WIDTH, 8, width of the beat-count inputs (at most 8).
- WORD_SIZE_BYTES, 4, address alignment granule (power of 2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_i  in  2  level request: bit0 write, bit1 read.
- axi_wr_addr_i  in  AXI_ADDR_WIDTH  write burst start address.
- axi_rd_addr_i  in  AXI_ADDR_WIDTH  read burst start address.
- axi_data_i  in  AXI_DATA_WIDTH  write data, sampled per beat.
- wr_data_count_i  in  DATA_COUNT_WIDTH  write AWLEN (beats-1).
- rd_data_count_i  in  DATA_COUNT_WIDTH  read ARLEN (beats-1).
- rsp_o  out  2  one-cycle done pulse: bit0 write, bit1 read.
- wr_err_o  out  2  last BRESP.
- rd_err_o  out  2  read burst response.
- axi_data_o  out  AXI_DATA_WIDTH  last RDATA beat received.
- axi_mgr_if  AXI_BUS manager modport  interface  AXI4 bus (ID/USER widths from the interface).

Behaviour:
- Reset, asynchronous, active-high: FSMs to IDLE; rsp_o, wr_err_o, rd_err_o, axi_data_o = 0; all valid/ready outputs = 0.
- Constant fields: ID 0, BURST INCR (01), LOCK/CACHE/PROT/QOS/REGION/USER/ATOP 0, WSTRB all ones, AxSIZE = log2(AXI_XSIZE).
- Address: latched input with low log2(WORD_SIZE_BYTES) bits cleared. No 4 KB splitting; the caller keeps bursts legal.
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE: when req_i[0]=1, latch address and count (AWLEN); go to W_AW next cycle.
  - W_AW: AWVALID=1 held stable until AWREADY; then W_DATA, beat counter=0.
  - W_DATA: WVALID=1, WDATA=axi_data_i (combinational), WLAST when counter==AWLEN; counter increments on WVALID&WREADY; after the last handshake go to W_RESP. W never precedes AW acceptance.
  - W_RESP: BREADY=1; on BVALID register wr_err_o=BRESP, pulse rsp_o[0] for 1 cycle, go to W_IDLE.
  - If req_i[0] is still high, a new burst starts (back-to-back repeats).
- Read FSM states: R_IDLE, R_AR, R_DATA.
  - R_IDLE: when req_i[1]=1, latch address/ARLEN; go to R_AR.
  - R_AR: ARVALID=1 until ARREADY.
  - R_DATA: RREADY=1. Each RVALID beat registers axi_data_o=RDATA. rd_err_o holds the first non-OKAY RRESP of the burst, else 0 (cleared at burst start).
  - On RVALID&RLAST: pulse rsp_o[1], go to R_IDLE. RLAST is trusted over the beat count.
- Write and read FSMs are fully independent; simultaneous requests proceed concurrently.
- wr_err_o/rd_err_o hold their value until the next completion of the same channel.
- Count 0 gives a single beat with WLAST on the first beat.
- req_i deasserted mid-burst does not abort the burst.
- Reset mid-burst aborts immediately; the subordinate must also be reset.

Test Plan:
- req_i=01, wr_addr 0x5000, data 0xDEADBEEF0B501E7E, count 7 -> AWADDR 0x5000, AWLEN 7, AWSIZE 3, AWBURST 01. Then 8 W beats of that data, WLAST only on the 8th, WSTRB 0xFF. B OKAY -> rsp_o[0] 1-cycle pulse, wr_err_o=0.
- req_i=10, rd_addr 0x6000, count 7, random-delay subordinate -> ARADDR 0x6000, ARLEN 7. 8 beats accepted; axi_data_o = 8th RDATA; rsp_o[1] pulses after RLAST; rd_err_o=0.
- req_i=11 held high with random-ready subordinate -> concurrent, repeated write and read bursts. VALID is never dropped before READY; no protocol errors.
- Count 0, address 0x5003 -> AWADDR 0x5000, AWLEN 0, single beat with WLAST=1.
- Subordinate returns BRESP=2 and RRESP=3 on beat 2 -> wr_err_o=2, rd_err_o=3, each held until the next completion.
- rst_i asserted during W_DATA -> WVALID/AWVALID drop asynchronously; outputs return to reset values; a new request after release starts cleanly.
